// File: rtl/nbit_register_file_sb.sv
// Register file with two write ports, two combinational read ports, optional
// write-to-read bypass, optional hardwired-zero r0, and a per-register busy scoreboard.

module nbit_rf_rd_port #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic [ADDR_W-1:0]             raddr,
  input  logic [DEPTH-1:0][DATA_W-1:0]  regs,
  input  logic [DEPTH-1:0]              busy,
  input  logic                          we_a,
  input  logic [ADDR_W-1:0]             waddr_a,
  input  logic [DATA_W-1:0]             wdata_a,
  input  logic                          we_b,
  input  logic [ADDR_W-1:0]             waddr_b,
  input  logic [DATA_W-1:0]             wdata_b,
  output logic [DATA_W-1:0]             rdata,
  output logic                          rbusy
);
  always_comb begin
    rdata = regs[raddr];
    rbusy = busy[raddr];
    // A same-cycle write means the result is arriving now, so the operand is not busy.
    if (BYPASS != 0) begin
      if (we_b && waddr_b == raddr) begin
        rdata = wdata_b;
        rbusy = 1'b0;
      end else if (we_a && waddr_a == raddr) begin
        rdata = wdata_a;
        rbusy = 1'b0;
      end
    end
    if (ZERO_REG != 0 && raddr == '0) begin
      rdata = '0;
      rbusy = 1'b0;
    end
  end
endmodule

module nbit_register_file_sb #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] waddr_a,
  input  logic [DATA_W-1:0] wdata_a,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] waddr_b,
  input  logic [DATA_W-1:0] wdata_b,
  input  logic [ADDR_W-1:0] raddr_1,
  output logic [DATA_W-1:0] rdata_1,
  output logic              rbusy_1,
  input  logic [ADDR_W-1:0] raddr_2,
  output logic [DATA_W-1:0] rdata_2,
  output logic              rbusy_2,
  input  logic              claim_en,
  input  logic [ADDR_W-1:0] claim_addr,
  output logic              claim_ok,
  output logic [DEPTH-1:0]  busy_vec
);
  localparam int  NUM_RD = 2;
  localparam bit  ZR     = (ZERO_REG != 0);

  logic [DEPTH-1:0][DATA_W-1:0]  regs;
  logic [DEPTH-1:0]              busy, busy_nxt;
  logic                          wr_a, wr_b;
  logic [NUM_RD-1:0][ADDR_W-1:0] raddr;
  logic [NUM_RD-1:0][DATA_W-1:0] rdata;
  logic [NUM_RD-1:0]             rbusy;

  assign wr_a     = we_a && !(ZR && waddr_a == '0);
  assign wr_b     = we_b && !(ZR && waddr_b == '0);
  assign claim_ok = claim_en && !busy[claim_addr] && !(ZR && claim_addr == '0);
  assign busy_vec = busy;

  // Clears from completing writes first, then the claim, so a claim against a
  // completing write leaves the bit set.
  always_comb begin
    busy_nxt = busy;
    if (we_a)     busy_nxt[waddr_a]    = 1'b0;
    if (we_b)     busy_nxt[waddr_b]    = 1'b0;
    if (claim_ok) busy_nxt[claim_addr] = 1'b1;
  end

  // Port B is applied last so it wins an address collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '0;
      busy <= '0;
    end else begin
      if (wr_a) regs[waddr_a] <= wdata_a;
      if (wr_b) regs[waddr_b] <= wdata_b;
      busy <= busy_nxt;
    end
  end

  assign raddr   = {raddr_2, raddr_1};
  assign rdata_1 = rdata[0];
  assign rdata_2 = rdata[1];
  assign rbusy_1 = rbusy[0];
  assign rbusy_2 = rbusy[1];

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    nbit_rf_rd_port #(
      .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
      .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
    ) u_rd (
      .raddr  (raddr[g]),
      .regs   (regs),
      .busy   (busy),
      .we_a   (we_a),
      .waddr_a(waddr_a),
      .wdata_a(wdata_a),
      .we_b   (we_b),
      .waddr_b(waddr_b),
      .wdata_b(wdata_b),
      .rdata  (rdata[g]),
      .rbusy  (rbusy[g])
    );
  end
endmodule

// File: tb/tb_nbit_register_file_sb.sv
// Directed bench: default build (32x32, zero reg, bypass) plus a 16-bit x 8 build
// without zero reg or bypass, sharing one clock and reset.

module tb_nbit_register_file_sb;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // default build
  logic        we_a, we_b, claim_en, claim_ok, rbusy_1, rbusy_2;
  logic [4:0]  waddr_a, waddr_b, raddr_1, raddr_2, claim_addr;
  logic [31:0] wdata_a, wdata_b, rdata_1, rdata_2, busy_vec;

  // small build
  logic        s_we_a, s_we_b, s_claim_en, s_claim_ok, s_rbusy_1, s_rbusy_2;
  logic [2:0]  s_waddr_a, s_waddr_b, s_raddr_1, s_raddr_2, s_claim_addr;
  logic [15:0] s_wdata_a, s_wdata_b, s_rdata_1, s_rdata_2;
  logic [7:0]  s_busy_vec;

  int pass_cnt = 0;
  int total_cnt = 0;

  nbit_register_file_sb dut (
    .clk(clk), .rst_n(rst_n),
    .we_a(we_a), .waddr_a(waddr_a), .wdata_a(wdata_a),
    .we_b(we_b), .waddr_b(waddr_b), .wdata_b(wdata_b),
    .raddr_1(raddr_1), .rdata_1(rdata_1), .rbusy_1(rbusy_1),
    .raddr_2(raddr_2), .rdata_2(rdata_2), .rbusy_2(rbusy_2),
    .claim_en(claim_en), .claim_addr(claim_addr), .claim_ok(claim_ok),
    .busy_vec(busy_vec)
  );

  nbit_register_file_sb #(
    .DATA_W(16), .DEPTH(8), .ADDR_W(3), .ZERO_REG(0), .BYPASS(0)
  ) dut_s (
    .clk(clk), .rst_n(rst_n),
    .we_a(s_we_a), .waddr_a(s_waddr_a), .wdata_a(s_wdata_a),
    .we_b(s_we_b), .waddr_b(s_waddr_b), .wdata_b(s_wdata_b),
    .raddr_1(s_raddr_1), .rdata_1(s_rdata_1), .rbusy_1(s_rbusy_1),
    .raddr_2(s_raddr_2), .rdata_2(s_rdata_2), .rbusy_2(s_rbusy_2),
    .claim_en(s_claim_en), .claim_addr(s_claim_addr), .claim_ok(s_claim_ok),
    .busy_vec(s_busy_vec)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we_a = 1'b0; we_b = 1'b0; claim_en = 1'b0;
  endtask

  task automatic s_idle();
    s_we_a = 1'b0; s_we_b = 1'b0; s_claim_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle(); s_idle();
    waddr_a = '0; waddr_b = '0; wdata_a = '0; wdata_b = '0;
    raddr_1 = '0; raddr_2 = '0; claim_addr = '0;
    s_waddr_a = '0; s_waddr_b = '0; s_wdata_a = '0; s_wdata_b = '0;
    s_raddr_1 = '0; s_raddr_2 = '0; s_claim_addr = '0;
    #12 rst_n = 1'b1;

    // reset state
    raddr_1 = 5; raddr_2 = 7; #1;
    check("rst_rdata", rdata_1, 0);
    check("rst_rbusy", rbusy_2, 0);
    check("rst_busy_vec", busy_vec, 0);
    check("s_rst_busy_vec", s_busy_vec, 0);

    // write r5, claim r7, then asynchronous reset between edges
    we_a = 1; waddr_a = 5; wdata_a = 32'hDEADBEEF;
    claim_en = 1; claim_addr = 7; #1;
    check("claim7_ok", claim_ok, 1);
    step(); idle(); #1;
    check("r5_written", rdata_1, 32'hDEADBEEF);
    check("busy7_set", busy_vec, 32'h0000_0080);
    check("rbusy7", rbusy_2, 1);
    #2 rst_n = 1'b0; #1;
    check("async_rst_rdata", rdata_1, 0);
    check("async_rst_busy", busy_vec, 0);
    rst_n = 1'b1;
    step();

    // dual write, same address: port B wins
    we_a = 1; waddr_a = 3; wdata_a = 32'h11111111;
    we_b = 1; waddr_b = 3; wdata_b = 32'h22222222;
    raddr_1 = 3; #1;
    check("bypass_b_prio", rdata_1, 32'h22222222);
    step(); idle(); #1;
    check("dual_same_addr", rdata_1, 32'h22222222);

    // dual write, separate addresses
    we_a = 1; waddr_a = 4; wdata_a = 32'h44444444;
    we_b = 1; waddr_b = 6; wdata_b = 32'h66666666;
    raddr_1 = 4; raddr_2 = 6;
    step(); idle(); #1;
    check("dual_r4", rdata_1, 32'h44444444);
    check("dual_r6", rdata_2, 32'h66666666);

    // bypass with busy masking on r9
    claim_en = 1; claim_addr = 9;
    step(); idle();
    raddr_1 = 9; raddr_2 = 9; #1;
    check("rbusy9_set", rbusy_1, 1);
    we_a = 1; waddr_a = 9; wdata_a = 32'hCAFE0001; #1;
    check("bypass_rdata1", rdata_1, 32'hCAFE0001);
    check("bypass_rdata2", rdata_2, 32'hCAFE0001);
    check("bypass_rbusy", rbusy_1, 0);
    check("busy_vec_unmasked", busy_vec, 32'h0000_0200);
    step(); idle(); #1;
    check("write_clears_busy9", busy_vec, 0);
    check("r9_stored", rdata_1, 32'hCAFE0001);

    // zero register
    we_a = 1; waddr_a = 0; wdata_a = 32'hFFFFFFFF;
    we_b = 1; waddr_b = 0; wdata_b = 32'h12345678;
    claim_en = 1; claim_addr = 0; raddr_1 = 0; #1;
    check("r0_bypass_zero", rdata_1, 0);
    check("r0_claim_refused", claim_ok, 0);
    check("r0_rbusy", rbusy_1, 0);
    step(); idle(); #1;
    check("r0_reads_zero", rdata_1, 0);
    check("r0_not_busy", busy_vec, 0);

    // scoreboard on r10
    claim_en = 1; claim_addr = 10; #1;
    check("claim10_ok", claim_ok, 1);
    step(); idle(); raddr_2 = 10; #1;
    check("busy10_set", busy_vec, 32'h0000_0400);
    check("rbusy10", rbusy_2, 1);
    claim_en = 1; claim_addr = 10; #1;
    check("reclaim10_refused", claim_ok, 0);
    step(); idle(); #1;
    check("busy10_unchanged", busy_vec, 32'h0000_0400);
    we_a = 1; waddr_a = 10; wdata_a = 32'h0000000A;
    step(); idle(); #1;
    check("busy10_cleared", busy_vec, 0);
    check("rbusy10_cleared", rbusy_2, 0);
    claim_en = 1; claim_addr = 10;
    we_b = 1; waddr_b = 10; wdata_b = 32'h0000000B; #1;
    check("claim_with_write_ok", claim_ok, 1);
    step(); idle(); #1;
    check("claim_wins_over_clear", busy_vec, 32'h0000_0400);
    check("r10_written", rdata_2, 32'h0000000B);

    // small build: r0 is ordinary, no bypass
    s_we_a = 1; s_waddr_a = 0; s_wdata_a = 16'hFFFF; s_raddr_1 = 0; #1;
    check("s_no_bypass_r0", s_rdata_1, 0);
    step(); s_idle(); #1;
    check("s_r0_stored", s_rdata_1, 16'hFFFF);
    s_claim_en = 1; s_claim_addr = 0; #1;
    check("s_claim0_ok", s_claim_ok, 1);
    step(); s_idle(); #1;
    check("s_busy0", s_busy_vec, 8'h01);
    check("s_rbusy0", s_rbusy_1, 1);

    s_claim_en = 1; s_claim_addr = 3;
    step(); s_idle();
    s_raddr_2 = 3; s_we_a = 1; s_waddr_a = 3; s_wdata_a = 16'h1234; #1;
    check("s_rbusy3_no_mask", s_rbusy_2, 1);
    check("s_r3_old_value", s_rdata_2, 0);
    step(); s_idle(); #1;
    check("s_rbusy3_cleared", s_rbusy_2, 0);
    check("s_r3_new_value", s_rdata_2, 16'h1234);

    // write/readback sweep of all 8 registers, two per cycle
    for (int i = 0; i < 8; i += 2) begin
      s_we_a = 1; s_waddr_a = 3'(i);     s_wdata_a = 16'hA5A5 ^ 16'(i);
      s_we_b = 1; s_waddr_b = 3'(i + 1); s_wdata_b = 16'hA5A5 ^ 16'(i + 1);
      step();
    end
    s_idle();
    for (int i = 0; i < 8; i++) begin
      s_raddr_1 = 3'(i); s_raddr_2 = 3'(7 - i); #1;
      check($sformatf("s_sweep1_r%0d", i), s_rdata_1, 16'hA5A5 ^ 16'(i));
      check($sformatf("s_sweep2_r%0d", 7 - i), s_rdata_2, 16'hA5A5 ^ 16'(7 - i));
    end
    check("s_busy_all_clear", s_busy_vec, 8'h00);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
